// File: rtl/coeff_ram_arbiter_pkg.sv
// coeff_ram_arbiter_pkg: shared arbiter state encoding, requester indices and log2 helper
package coeff_ram_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_t;
  localparam int REQ_STP = 0;
  localparam int REQ_EVP = 1;
  localparam int REQ_EVB = 2;
  // ceil(log2(v)); the first i with 2**i >= v
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/coeff_ram_arbiter_rr_priority_picker.sv
// rr_priority_picker: first eligible requester scanning upward from i_start, modulo N
// Ports: i_req requests, i_start scan start index, i_excl mask of requesters to skip,
//        o_win one-hot winner (zero if none), o_found any winner
module rr_priority_picker import coeff_ram_arbiter_pkg::*; #(
  parameter int N  = 3,
  parameter int PW = log2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_start,
  input  logic [N-1:0]  i_excl,
  output logic [N-1:0]  o_win,
  output logic          o_found
);
  logic [N-1:0]   w_cand, w_sel;
  logic [2*N-1:0] w_dbl, w_back;
  assign w_cand  = i_req & ~i_excl;
  assign o_found = |w_cand;
  // rotate so i_start sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    w_dbl = {w_cand, w_cand} >> i_start;
    w_sel = '0;
    for (int k = N - 1; k >= 0; k--) if (w_dbl[k]) w_sel = N'(1) << k;
    w_back = {w_sel, w_sel} << i_start;
    o_win  = w_back[2*N-1:N];
  end
endmodule

// File: rtl/coeff_ram_arbiter.sv
// coeff_ram_arbiter: round-robin, burst-locked sharing of one single-port coefficient RAM
// Ports: req/we/addr_in/wdata_in per-requester operands; gnt registered one-hot grant;
//        rd_valid registered read-return strobe; ram_* muxed RAM controls; busy while owned
module coeff_ram_arbiter import coeff_ram_arbiter_pkg::*; #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int NUM_REQ     = 3,
  parameter int MAX_BURST   = 8,
  localparam int AW = log2(buffer_size)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           we,
  input  logic [NUM_REQ*AW-1:0]        addr_in,
  input  logic [NUM_REQ*word_size-1:0] wdata_in,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rd_valid,
  output logic [AW-1:0]                ram_addr,
  output logic [word_size-1:0]         ram_wdata,
  output logic                         ram_wr_en,
  output logic                         ram_rd_en,
  output logic                         busy
);
  localparam int PW = log2(NUM_REQ);
  localparam int BW = log2(MAX_BURST) + 1;
  arb_state_t          r_state, w_state_n;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_n, r_rd_valid, w_xfer, w_excl, w_win;
  logic [PW-1:0]       r_rr_ptr, w_rr_ptr_n, w_owner, w_owner_inc, w_start;
  logic [BW-1:0]       r_burst_cnt, w_burst_n;
  logic                w_found, w_owner_req, w_release;
  assign w_xfer      = r_gnt & req;
  assign w_owner_req = |w_xfer;
  assign w_owner_inc = (w_owner == PW'(NUM_REQ - 1)) ? '0 : w_owner + 1'b1;
  assign w_release   = ~w_owner_req | (r_burst_cnt == BW'(MAX_BURST - 1));
  // on release the scan restarts just past the owner; a dropped owner is excluded
  assign w_start     = (r_state == OWN) ? w_owner_inc : r_rr_ptr;
  assign w_excl      = (r_state == OWN && !w_owner_req) ? r_gnt : '0;
  rr_priority_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .i_req   (req),
    .i_start (w_start),
    .i_excl  (w_excl),
    .o_win   (w_win),
    .o_found (w_found)
  );
  always_comb begin
    w_owner   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        w_owner   = PW'(i);
        ram_addr  = addr_in[i*AW +: AW];
        ram_wdata = wdata_in[i*word_size +: word_size];
      end
    end
  end
  always_comb begin
    w_state_n  = r_state;
    w_gnt_n    = r_gnt;
    w_rr_ptr_n = r_rr_ptr;
    w_burst_n  = r_burst_cnt + BW'(w_owner_req);
    if (r_state == IDLE || w_release) begin
      w_rr_ptr_n = w_start;
      w_gnt_n    = w_win;
      w_burst_n  = '0;
      w_state_n  = w_found ? OWN : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_rd_valid  <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_gnt       <= w_gnt_n;
      r_rd_valid  <= w_xfer & ~we;
      r_rr_ptr    <= w_rr_ptr_n;
      r_burst_cnt <= w_burst_n;
    end
  end
  assign gnt       = r_gnt;
  assign rd_valid  = r_rd_valid;
  assign busy      = (r_state == OWN);
  assign ram_wr_en = |(w_xfer & we);
  assign ram_rd_en = |(w_xfer & ~we);
endmodule

// File: tb/tb_coeff_ram_arbiter.sv
// tb_coeff_ram_arbiter: directed self-checking bench for coeff_ram_arbiter
module tb_coeff_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0, we = '0;
  logic [29:0] addr_in = '0;
  logic [47:0] wdata_in = '0;
  logic [2:0]  gnt, rd_valid;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wr_en, ram_rd_en, busy;
  int checks = 0, errors = 0;
  logic [2:0] prev_rv, exp_g;
  coeff_ram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
    .gnt(gnt), .rd_valid(rd_valid), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic rst_pulse;
    rst = 1'b1;
    req = '0;
    we  = '0;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", ram_wr_en, 0);
    chk("rst_rd", ram_rd_en, 0);
    chk("rst_addr", ram_addr, 0);
    // single read by EVP
    rst_pulse;
    req = 3'b010; we = 3'b000; addr_in[10 +: 10] = 10'h005;
    #1 chk("t1_c0_gnt", gnt, 0);
    tick; #1;
    chk("t1_c1_gnt", gnt, 3'b010);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_rd", ram_rd_en, 1);
    chk("t1_c1_wr", ram_wr_en, 0);
    chk("t1_c1_addr", ram_addr, 10'h005);
    chk("t1_c1_rdv", rd_valid, 0);
    tick; req = 3'b000; #1;
    chk("t1_c2_rdv", rd_valid, 3'b010);
    chk("t1_c2_rd", ram_rd_en, 0);
    tick; #1;
    chk("t1_c3_gnt", gnt, 0);
    chk("t1_c3_busy", busy, 0);
    chk("t1_c3_rdv", rd_valid, 0);
    // contention from idle: STP, EVP, EVB, STP, 8 transfers each, no gaps
    rst_pulse;
    req = 3'b111; we = 3'b001;
    addr_in = {10'h3, 10'h2, 10'h1};
    prev_rv = 3'b000;
    #1 chk("t2_c0_gnt", gnt, 0);
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 8; k++) begin
        tick; #1;
        exp_g = 3'b001 << (o % 3);
        chk($sformatf("t2_o%0d_k%0d_gnt", o, k), gnt, exp_g);
        chk($sformatf("t2_o%0d_k%0d_busy", o, k), busy, 1);
        chk($sformatf("t2_o%0d_k%0d_wr", o, k), ram_wr_en, (o % 3 == 0) ? 1 : 0);
        chk($sformatf("t2_o%0d_k%0d_rdv", o, k), rd_valid, prev_rv);
        prev_rv = (o % 3 == 0) ? 3'b000 : exp_g;
      end
    end
    tick; req = 3'b000; #1;
    chk("t2_after_gnt", gnt, 3'b010);
    chk("t2_after_rd", ram_rd_en, 0);
    tick; #1;
    chk("t2_idle_busy", busy, 0);
    // sole requester STP writes 0..19 across burst boundaries
    rst_pulse;
    req = 3'b001; we = 3'b001;
    #1;
    for (int n = 0; n < 20; n++) begin
      tick;
      addr_in[9:0] = 10'(n);
      wdata_in[15:0] = 16'hA000 + 16'(n);
      #1;
      chk($sformatf("t3_n%0d_gnt", n), gnt, 3'b001);
      chk($sformatf("t3_n%0d_wr", n), ram_wr_en, 1);
      chk($sformatf("t3_n%0d_addr", n), ram_addr, n);
      chk($sformatf("t3_n%0d_wdata", n), ram_wdata, 32'hA000 + n);
      chk($sformatf("t3_n%0d_rdv", n), rd_valid, 0);
    end
    tick; req = 3'b000; #1;
    chk("t3_drop_wr", ram_wr_en, 0);
    tick; #1;
    chk("t3_end_gnt", gnt, 0);
    // early drop: EVB reads 3 times, then drops while STP waits
    rst_pulse;
    req = 3'b100; we = 3'b000; addr_in[20 +: 10] = 10'h010;
    #1;
    tick; req = 3'b101; we = 3'b001; #1;
    chk("t4_c1_gnt", gnt, 3'b100);
    chk("t4_c1_rd", ram_rd_en, 1);
    chk("t4_c1_addr", ram_addr, 10'h010);
    tick; addr_in[20 +: 10] = 10'h011; #1;
    chk("t4_c2_gnt", gnt, 3'b100);
    chk("t4_c2_rdv", rd_valid, 3'b100);
    chk("t4_c2_addr", ram_addr, 10'h011);
    tick; addr_in[20 +: 10] = 10'h012; #1;
    chk("t4_c3_rdv", rd_valid, 3'b100);
    chk("t4_c3_rd", ram_rd_en, 1);
    tick; req = 3'b001; #1;
    chk("t4_c4_gnt", gnt, 3'b100);
    chk("t4_c4_rdv", rd_valid, 3'b100);
    chk("t4_c4_rd", ram_rd_en, 0);
    chk("t4_c4_wr", ram_wr_en, 0);
    tick; #1;
    chk("t4_c5_gnt", gnt, 3'b001);
    chk("t4_c5_rdv", rd_valid, 0);
    chk("t4_c5_wr", ram_wr_en, 1);
    chk("t4_c5_ptr", dut.r_rr_ptr, 0);
    // reset in the cycle after an EVP read
    rst_pulse;
    req = 3'b010; we = 3'b000; addr_in[10 +: 10] = 10'h007;
    #1;
    tick; #1;
    chk("t5_c1_rd", ram_rd_en, 1);
    tick; rst = 1'b1; #1;
    chk("t5_c2_rdv", rd_valid, 3'b010);
    tick; rst = 1'b0; req = 3'b110; we = 3'b000; #1;
    chk("t5_c3_rdv", rd_valid, 0);
    chk("t5_c3_gnt", gnt, 0);
    chk("t5_c3_busy", busy, 0);
    tick; #1;
    chk("t5_c4_gnt", gnt, 3'b010);
    // EVB exhausts its burst with STP waiting: pointer wraps to 0
    rst_pulse;
    req = 3'b100; we = 3'b000;
    #1;
    tick; req = 3'b101; we = 3'b001; #1;
    chk("t6_k0_gnt", gnt, 3'b100);
    for (int k = 1; k < 8; k++) begin
      tick; #1;
      chk($sformatf("t6_k%0d_gnt", k), gnt, 3'b100);
    end
    tick; #1;
    chk("t6_wrap_gnt", gnt, 3'b001);
    chk("t6_wrap_ptr", dut.r_rr_ptr, 0);
    req = 3'b000;
    tick;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
